// File: rtl/dispatch_round_robin.sv
// dispatch_round_robin
//   Spreads one valid/ready input stream across WID output lanes in
//   round-robin order. Busy lanes are skipped, and the lowest lane index wins
//   among the candidates. Each lane owns a 1-entry registered slot. A slot
//   that is popped in the same cycle counts as free, so a lane can sustain
//   one beat per cycle.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_vld     input beat valid
//   in_rdy     input beat accepted when in_vld & in_rdy (combinational on out_rdy)
//   in_dat     input beat data
//   out_vld    per-lane slot full
//   out_rdy    per-lane consumer ready
//   out_dat    lane i data at [i*DAT_WID +: DAT_WID]
//   disp_lane  one-hot lane written this cycle, 0 when nothing is pushed
module dispatch_round_robin #(
  parameter int WID     = 4,
  parameter int DAT_WID = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [DAT_WID-1:0]     in_dat,
  output logic [WID-1:0]         out_vld,
  input  logic [WID-1:0]         out_rdy,
  output logic [WID*DAT_WID-1:0] out_dat,
  output logic [WID-1:0]         disp_lane
);

  logic [WID-1:0]         full_r;
  logic [WID-1:0]         mask_r;
  logic [WID*DAT_WID-1:0] data_r;

  logic [WID-1:0] free_s;
  logic [WID-1:0] cand_s;
  logic [WID-1:0] sel_m_s;
  logic [WID-1:0] sel_b_s;
  logic [WID-1:0] sel_s;
  logic [WID-1:0] mask_nxt_s;
  logic           push_s;

  // Isolate the lowest set bit. A loop form is used so that WID=1 needs no special case.
  function automatic logic [WID-1:0] lowest_one(input logic [WID-1:0] v);
    logic [WID-1:0] r;
    logic           found;
    r     = {WID{1'b0}};
    found = 1'b0;
    for (int i = 0; i < WID; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end else begin
        r[i] = r[i];
      end
    end
    return r;
  endfunction

  // Return the bits strictly above the one-hot select. Selecting the top lane
  // leaves nothing above it, so the mask wraps back to all ones.
  function automatic logic [WID-1:0] mask_above(input logic [WID-1:0] sel);
    logic [WID-1:0] r;
    logic           seen;
    r    = {WID{1'b0}};
    seen = 1'b0;
    for (int i = 0; i < WID; i++) begin
      r[i] = seen;
      if (sel[i]) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
    end
    if (r == {WID{1'b0}}) begin
      r = {WID{1'b1}};
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Select a free lane: prefer lanes above the last dispatch, otherwise wrap to the lowest free lane.
  always_comb begin
    free_s  = ~full_r | out_rdy;
    cand_s  = free_s & mask_r;
    sel_m_s = lowest_one(cand_s);
    sel_b_s = lowest_one(free_s);
    if (cand_s != {WID{1'b0}}) begin
      sel_s = sel_m_s;
    end else begin
      sel_s = sel_b_s;
    end
    in_rdy = |free_s;
    push_s = in_vld & in_rdy;
    if (push_s) begin
      disp_lane = sel_s;
    end else begin
      disp_lane = {WID{1'b0}};
    end
    mask_nxt_s = mask_above(sel_s);
  end

  // Slot occupancy, slot data and round-robin mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= {WID{1'b0}};
      data_r <= {(WID*DAT_WID){1'b0}};
      mask_r <= {WID{1'b1}};
    end else begin
      for (int i = 0; i < WID; i++) begin
        if (push_s && sel_s[i]) begin
          // A push wins over a same-cycle pop, so the slot stays full with the new beat.
          full_r[i]                      <= 1'b1;
          data_r[i*DAT_WID +: DAT_WID]   <= in_dat;
        end else if (out_rdy[i]) begin
          full_r[i] <= 1'b0;
        end else begin
          full_r[i] <= full_r[i];
        end
      end
      if (push_s) begin
        mask_r <= mask_nxt_s;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  assign out_vld = full_r;
  assign out_dat = data_r;

endmodule

// File: tb/tb_dispatch_round_robin.sv
module tb_dispatch_round_robin;
  localparam int W = 4;
  localparam int D = 8;

  logic           clk;
  logic           rst_n;
  logic           in_vld;
  logic           in_rdy;
  logic [D-1:0]   in_dat;
  logic [W-1:0]   out_vld;
  logic [W-1:0]   out_rdy;
  logic [W*D-1:0] out_dat;
  logic [W-1:0]   disp_lane;

  dispatch_round_robin #(.WID(W), .DAT_WID(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .disp_lane(disp_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;

  // Reference model: a slot per lane, plus the index of the last dispatched lane.
  bit           m_full [W];
  logic [D-1:0] m_data [W];
  int           m_last;

  // Observations from the most recent step.
  logic           obs_rdy;
  logic [W-1:0]   obs_disp;
  logic [W-1:0]   obs_vld;
  logic [W*D-1:0] obs_dat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = 8'h00;
    end
    m_last = -1;
  endtask

  // Search for a free lane: first after the last dispatch, then wrap from lane 0.
  function automatic int pick(input logic [W-1:0] r);
    int s;
    s = -1;
    for (int i = m_last + 1; i < W; i++)
      if (s < 0 && (!m_full[i] || r[i])) s = i;
    for (int i = 0; i < W; i++)
      if (s < 0 && (!m_full[i] || r[i])) s = i;
    return s;
  endfunction

  // One cycle: drive at negedge, compare with the model, then advance the model across the next edge.
  task automatic step(input logic v, input logic [D-1:0] d, input logic [W-1:0] r);
    int             s;
    logic           e_rdy;
    logic [W-1:0]   e_disp;
    logic [W-1:0]   e_vld;
    logic [W*D-1:0] e_dat;
    @(negedge clk);
    in_vld  = v;
    in_dat  = d;
    out_rdy = r;
    #1;
    obs_rdy  = in_rdy;
    obs_disp = disp_lane;
    obs_vld  = out_vld;
    obs_dat  = out_dat;
    s      = pick(r);
    e_rdy  = (s >= 0);
    e_disp = (v && s >= 0) ? (4'b0001 << s) : 4'b0000;
    for (int i = 0; i < W; i++) begin
      e_vld[i]       = m_full[i];
      e_dat[i*D +: D] = m_data[i];
    end
    chk("in_rdy", 64'(obs_rdy), 64'(e_rdy));
    chk("disp_lane", 64'(obs_disp), 64'(e_disp));
    chk("out_vld", 64'(obs_vld), 64'(e_vld));
    chk("out_dat", 64'(obs_dat), 64'(e_dat));
    for (int i = 0; i < W; i++) begin
      if (v && s == i) begin
        m_full[i] = 1'b1;
        m_data[i] = d;
      end else if (r[i]) begin
        m_full[i] = 1'b0;
      end
    end
    if (v && s >= 0) m_last = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_vld  = 1'b0;
    out_rdy = 4'b0000;
    rst_n   = 1'b0;
    #1;
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_dat  = 8'h00;
    out_rdy = 4'b0000;
    model_reset();
    #12;
    chk("reset_out_vld", 64'(out_vld), 64'h0);
    chk("reset_out_dat", 64'(out_dat), 64'h0);
    rst_n = 1'b1;

    // 1: full throughput, lanes visited in order 0..3 and then wrapping
    step(1'b1, 8'h11, 4'b1111); chk("t1_d0", 64'(obs_disp), 64'h1); chk("t1_r0", 64'(obs_rdy), 64'h1);
    step(1'b1, 8'h22, 4'b1111); chk("t1_d1", 64'(obs_disp), 64'h2);
    chk("t1_vld0", 64'(obs_vld), 64'h1); chk("t1_dat0", 64'(obs_dat[7:0]), 64'h11);
    step(1'b1, 8'h33, 4'b1111); chk("t1_d2", 64'(obs_disp), 64'h4);
    step(1'b1, 8'h44, 4'b1111); chk("t1_d3", 64'(obs_disp), 64'h8);
    step(1'b1, 8'h55, 4'b1111); chk("t1_d4", 64'(obs_disp), 64'h1); chk("t1_r4", 64'(obs_rdy), 64'h1);
    step(1'b0, 8'h00, 4'b0000); chk("t1_dat0b", 64'(obs_dat[7:0]), 64'h55);

    // 2: back-pressure, then the held beat enters lane 2 once that lane frees
    do_reset();
    step(1'b1, 8'hA0, 4'b0000);
    step(1'b1, 8'hA1, 4'b0000);
    step(1'b1, 8'hA2, 4'b0000);
    step(1'b1, 8'hA3, 4'b0000);
    step(1'b1, 8'hA4, 4'b0000); chk("t2_rdy0", 64'(obs_rdy), 64'h0); chk("t2_nodisp", 64'(obs_disp), 64'h0);
    chk("t2_dat", 64'(obs_dat), 64'hA3A2A1A0);
    step(1'b1, 8'hA4, 4'b0100); chk("t2_disp2", 64'(obs_disp), 64'h4);
    step(1'b0, 8'h00, 4'b0000); chk("t2_lane2", 64'(obs_dat[23:16]), 64'hA4); chk("t2_vld", 64'(obs_vld), 64'hF);

    // 3: after the top lane, wrap to lane 0, but lane 0 is busy so lane 1 is chosen
    do_reset();
    for (int i = 0; i < W; i++) step(1'b1, 8'(i), 4'b0000);
    step(1'b0, 8'h00, 4'b1110);
    step(1'b1, 8'h77, 4'b0000); chk("t3_disp1", 64'(obs_disp), 64'h2); chk("t3_vld", 64'(obs_vld), 64'h1);

    // 4: pop and push on the same lane in the same cycle
    do_reset();
    step(1'b1, 8'h00, 4'b0000);
    step(1'b1, 8'h10, 4'b0000);
    step(1'b1, 8'h02, 4'b0000);
    step(1'b1, 8'h03, 4'b0000);
    step(1'b1, 8'h20, 4'b0010); chk("t4_disp1", 64'(obs_disp), 64'h2); chk("t4_old", 64'(obs_dat[15:8]), 64'h10);
    step(1'b0, 8'h00, 4'b0000); chk("t4_vld", 64'(obs_vld), 64'hF); chk("t4_new", 64'(obs_dat[15:8]), 64'h20);

    // 5: idle cycles do not move the mask
    do_reset();
    step(1'b1, 8'h01, 4'b1111);
    step(1'b1, 8'h02, 4'b1111);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 4'b1111);
    step(1'b1, 8'h03, 4'b1111); chk("t5_disp2", 64'(obs_disp), 64'h4);

    // 6: asynchronous reset in the middle of a cycle
    do_reset();
    for (int i = 0; i < W; i++) step(1'b1, 8'(8'hC0 + i), 4'b0000);
    step(1'b0, 8'h00, 4'b0000); chk("t6_full", 64'(obs_vld), 64'hF);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_vld0", 64'(out_vld), 64'h0);
    chk("t6_dat0", 64'(out_dat), 64'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    step(1'b1, 8'h99, 4'b1111); chk("t6_disp0", 64'(obs_disp), 64'h1);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
